viterbi_traceback: RTL and testbench

Traceback unit of a 4-state (constraint length 3) Viterbi decoder. Starting from a selected end node, it walks the survivor path backwards one trellis stage per clock, using the per-state predecessor pointers supplied by the survivor memory. It emits one decoded bit per stage and delivers an 8-bit decoded word with a completion flag. It sits between the add-compare-select/survivor-memory stage and the decoded-data sink.

---
 rtl/viterbi_pkg.sv | 29 ++
 rtl/viterbi_traceback_if.sv | 36 +++
 rtl/trbk_prev_mux.sv | 31 +++
 rtl/viterbi_traceback.sv | 105 ++++++++++
 tb/tb_viterbi_traceback.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// ============================================================================
// Module      : viterbi_pkg
// Description : Shared types and constants for the Viterbi traceback slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package viterbi_pkg;

  typedef logic [1:0] st_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam int TB_DEPTH_DEF = 8;

  // Guard against a zero-width counter when depth is 1.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int CNT_W = cnt_width(TB_DEPTH_DEF);

endpackage

`default_nettype wire

// File: rtl/viterbi_traceback_if.sv
// ============================================================================
// Module      : viterbi_traceback_if
// Description : Survivor-memory to traceback bus, with decoded-word return.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface viterbi_traceback_if #(
  parameter int TB_DEPTH = viterbi_pkg::TB_DEPTH_DEF
);
  import viterbi_pkg::*;

  logic                en_trbk;
  st_t                 i_slt_node;
  st_t                 i_bck_prev_st_00;
  st_t                 i_bck_prev_st_10;
  st_t                 i_bck_prev_st_01;
  st_t                 i_bck_prev_st_11;
  logic [TB_DEPTH-1:0] o_data;
  logic                o_done;

  modport master (
    output en_trbk, i_slt_node,
    output i_bck_prev_st_00, i_bck_prev_st_10, i_bck_prev_st_01, i_bck_prev_st_11,
    input  o_data, o_done
  );

  modport slave (
    input  en_trbk, i_slt_node,
    input  i_bck_prev_st_00, i_bck_prev_st_10, i_bck_prev_st_01, i_bck_prev_st_11,
    output o_data, o_done
  );

endinterface

`default_nettype wire

// File: rtl/trbk_prev_mux.sv
// ============================================================================
// Module      : trbk_prev_mux
// Description : 4:1 predecessor select indexed by the current trellis state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trbk_prev_mux
  import viterbi_pkg::*;
(
  input  wire st_t i_sel,
  input  wire st_t i_prev_00,
  input  wire st_t i_prev_10,
  input  wire st_t i_prev_01,
  input  wire st_t i_prev_11,
  output st_t      o_prev
);

  always_comb begin
    o_prev = i_prev_00;
    case (i_sel)
      2'b00:   o_prev = i_prev_00;
      2'b01:   o_prev = i_prev_01;
      2'b10:   o_prev = i_prev_10;
      default: o_prev = i_prev_11;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/viterbi_traceback.sv
// ============================================================================
// Module      : viterbi_traceback
// Description : 4-state Viterbi traceback, one stage per clock, TB_DEPTH-bit
//               decoded word. TRACEBACK_REVERSE_EN selects bit-reversed output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = TB_DEPTH_DEF
) (
  input  wire                  clk,
  input  wire                  rst,
  viterbi_traceback_if.slave   bus
);

  localparam int                C_CNT_W = cnt_width(TB_DEPTH);
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(TB_DEPTH - 1);

  fsm_t                r_state, w_state_nxt;
  st_t                 r_cur_st, w_cur_nxt;
  logic [C_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [TB_DEPTH-1:0] r_data, w_data_nxt;
  logic                r_done, w_done_nxt;
  st_t                 w_prev;
  logic [C_CNT_W-1:0]  w_bit_idx;

  trbk_prev_mux u_prev_mux (
    .i_sel     (r_cur_st),
    .i_prev_00 (bus.i_bck_prev_st_00),
    .i_prev_10 (bus.i_bck_prev_st_10),
    .i_prev_01 (bus.i_bck_prev_st_01),
    .i_prev_11 (bus.i_bck_prev_st_11),
    .o_prev    (w_prev)
  );

`ifdef TRACEBACK_REVERSE_EN
  assign w_bit_idx = r_cnt;
`else
  // Newest bit lands in the MSB so o_data[i] is the bit of trellis time i.
  assign w_bit_idx = C_LAST - r_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cur_st <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cur_st <= w_cur_nxt;
      r_cnt    <= w_cnt_nxt;
      r_data   <= w_data_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_st;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_done_nxt  = r_done;
    case (r_state)
      IDLE: begin
        if (bus.en_trbk) begin
          w_cur_nxt   = bus.i_slt_node;
          w_cnt_nxt   = '0;
          w_data_nxt  = '0;
          w_state_nxt = TRACE;
        end
      end
      TRACE: begin
        if (!bus.en_trbk) begin
          w_state_nxt = IDLE;
        end else begin
          w_data_nxt[w_bit_idx] = r_cur_st[1];
          w_cur_nxt             = w_prev;
          w_cnt_nxt             = r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      DONE: begin
        if (!bus.en_trbk) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.o_data = r_data;
  assign bus.o_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_viterbi_traceback.sv
// ============================================================================
// Module      : tb_viterbi_traceback
// Description : Randomized self-checking bench for viterbi_traceback against a
//               path-walking reference model. Honours TRACEBACK_REVERSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_viterbi_traceback;
  import viterbi_pkg::*;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [1:0] stage_pred [D][4];

  viterbi_traceback_if #(.TB_DEPTH(D)) bus ();

  viterbi_traceback #(.TB_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: follow the survivor path from the end node, newest bit first.
  function automatic logic [D-1:0] model_word(input logic [1:0] node, input int nsteps);
    logic [D-1:0] w = '0;
    logic [1:0]   s = node;
    for (int k = 0; k < nsteps; k++) begin
`ifdef TRACEBACK_REVERSE_EN
      w[k] = s[1];
`else
      w[D-1-k] = s[1];
`endif
      s = stage_pred[k][s];
    end
    return w;
  endfunction

  task automatic set_default_preds();
    for (int k = 0; k < D; k++) begin
      stage_pred[k][0] = 2'b00;
      stage_pred[k][2] = 2'b00;
      stage_pred[k][1] = 2'b10;
      stage_pred[k][3] = 2'b10;
    end
  endtask

  task automatic set_random_preds();
    for (int k = 0; k < D; k++)
      for (int s = 0; s < 4; s++)
        stage_pred[k][s] = 2'($urandom_range(0, 3));
  endtask

  task automatic drive_stage(input int k);
    bus.i_bck_prev_st_00 = stage_pred[k][0];
    bus.i_bck_prev_st_01 = stage_pred[k][1];
    bus.i_bck_prev_st_10 = stage_pred[k][2];
    bus.i_bck_prev_st_11 = stage_pred[k][3];
  endtask

  task automatic drive_noise();
    bus.i_bck_prev_st_00 = 2'($urandom_range(0, 3));
    bus.i_bck_prev_st_01 = 2'($urandom_range(0, 3));
    bus.i_bck_prev_st_10 = 2'($urandom_range(0, 3));
    bus.i_bck_prev_st_11 = 2'($urandom_range(0, 3));
  endtask

  // Load edge followed by nsteps trace edges; a full run checks done timing.
  task automatic run_trace(input logic [1:0] node, input int nsteps);
    bus.en_trbk    = 1'b1;
    bus.i_slt_node = node;
    drive_noise();
    step();
    bus.i_slt_node = 2'($urandom_range(0, 3));
    check_val("load_clear", 32'(bus.o_data), 32'(0));
    check_val("load_done", 32'(bus.o_done), 32'(0));
    for (int k = 0; k < nsteps; k++) begin
      drive_stage(k);
      step();
      if (k < D - 1) check_val("busy_done", 32'(bus.o_done), 32'(0));
    end
    if (nsteps == D) begin
      check_val("done_flag", 32'(bus.o_done), 32'(1));
      check_val("done_data", 32'(bus.o_data), 32'(model_word(node, D)));
    end
  endtask

  task automatic hold_and_release(input logic [1:0] node);
    logic [D-1:0] exp = model_word(node, D);
    for (int c = 0; c < 3; c++) begin
      drive_noise();
      step();
      check_val("hold_done", 32'(bus.o_done), 32'(1));
      check_val("hold_data", 32'(bus.o_data), 32'(exp));
    end
    bus.en_trbk = 1'b0;
    step();
    check_val("release_done", 32'(bus.o_done), 32'(0));
    check_val("release_data", 32'(bus.o_data), 32'(exp));
  endtask

  initial begin
    logic [1:0] node;
    bus.en_trbk    = 1'b0;
    bus.i_slt_node = 2'b00;
    drive_noise();
    set_default_preds();
    rst = 1'b1;
    step();
    step();
    check_val("reset_data", 32'(bus.o_data), 32'(0));
    check_val("reset_done", 32'(bus.o_done), 32'(0));
    rst = 1'b0;
    step();
    check_val("idle_done", 32'(bus.o_done), 32'(0));

    // Directed paths with the reference predecessor table.
    run_trace(2'b00, D);
    check_val("node00_word", 32'(bus.o_data), 32'(model_word(2'b00, D)));
    hold_and_release(2'b00);
    run_trace(2'b11, D);
`ifdef TRACEBACK_REVERSE_EN
    check_val("node11_word", 32'(bus.o_data), 32'h03);
`else
    check_val("node11_word", 32'(bus.o_data), 32'hC0);
`endif
    hold_and_release(2'b11);
    run_trace(2'b01, D);
`ifdef TRACEBACK_REVERSE_EN
    check_val("node01_word", 32'(bus.o_data), 32'h02);
`else
    check_val("node01_word", 32'(bus.o_data), 32'h40);
`endif
    hold_and_release(2'b01);

    // Abort after three steps, then restart cleanly.
    set_random_preds();
    node = 2'($urandom_range(0, 3));
    run_trace(node, 3);
    bus.en_trbk = 1'b0;
    step();
    check_val("abort_done", 32'(bus.o_done), 32'(0));
    check_val("abort_data", 32'(bus.o_data), 32'(model_word(node, 3)));
    drive_noise();
    step();
    check_val("abort_idle_done", 32'(bus.o_done), 32'(0));
    set_default_preds();
    run_trace(2'b11, D);
    hold_and_release(2'b11);

    // Reset mid-trace with enable held high.
    set_random_preds();
    run_trace(2'b10, 3);
    rst = 1'b1;
    step();
    check_val("rst_mid_data", 32'(bus.o_data), 32'(0));
    check_val("rst_mid_done", 32'(bus.o_done), 32'(0));
    rst = 1'b0;
    node = 2'($urandom_range(0, 3));
    run_trace(node, D);

    // Reset after done with enable still high.
    rst = 1'b1;
    step();
    check_val("rst_done_data", 32'(bus.o_data), 32'(0));
    check_val("rst_done_done", 32'(bus.o_done), 32'(0));
    rst = 1'b0;
    node = 2'($urandom_range(0, 3));
    run_trace(node, D);
    hold_and_release(node);

    // Randomized paths with per-stage predecessor sets.
    for (int it = 0; it < 12; it++) begin
      set_random_preds();
      node = 2'($urandom_range(0, 3));
      run_trace(node, D);
      hold_and_release(node);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
